if_stage_fsm: RTL and testbench
===============================

// Module: if_stage_fsm
// PURPOSE
//  Parametrised instruction-fetch stage with built-in IF/ID pipeline register and debug loader FSM.
//  Holds the instruction memory, PC, next-PC mux and the registered fetch output consumed by ID.
//  Adds word-addressed PC wrap, wrong-path squash on redirect, single-step mode and halt detection.
//  Sits between the debug unit (load/run/step) and the ID stage of the MIPS pipeline.
// PARAMETERS
//  len_data   32            instruction / address word width
//  ram_depth  2048          instruction memory depth in words
//  len_addr   $clog2(ram_depth)  internal PC width; PC is word-addressed
//  RESET_PC   0             PC value after reset
//  HALT_WORD  32'hFFFFFFFF  instruction encoding that halts fetch
//  NOP_WORD   32'h00000000  bubble inserted into ID on squash
// PORTS
//  clk              in   1         clock, all state on rising edge
//  reset            in   1         synchronous, active-high
//  in_pc_src        in   2         0 seq, 1 in_branch_address, 2 in_pc_jump, 3 in_pc_register
//  in_branch_address in  len_data  branch target (word address)
//  in_pc_jump       in   len_data  jump target
//  in_pc_register   in   len_data  jr/jalr target
//  stall_flag       in   1         hazard stall: hold PC and IF/ID
//  in_load_valid    in   1         loader write request
//  in_load_addr     in   len_data  loader word address
//  in_load_data     in   len_data  loader instruction word
//  out_load_ready   out  1         1 only in LOAD state
//  run_cmd          in   1         pulse: LOAD -> RUN
//  step_cmd         in   1         pulse: LOAD -> STEP; in STEP, enables one fetch
//  out_instruction  out  len_data  IF/ID instruction
//  out_pc           out  len_data  PC of out_instruction, zero-extended
//  out_pc_branch    out  len_data  out_pc+1 (wrapped), zero-extended
//  out_valid        out  1         out_instruction is a real fetched instruction
//  out_halt_flag_if out  1         HALT_WORD has been fetched
//  out_state        out  2         00 LOAD, 01 RUN, 10 STEP, 11 HALT
// BEHAVIOUR
//  Reset: state LOAD, pc=RESET_PC, out_instruction=NOP_WORD, out_pc=0, out_pc_branch=0,
//   out_valid=0, out_halt_flag_if=0. Memory contents retained across reset (incl. mid-load).
//  LOAD: out_load_ready=1; valid&ready writes mem[in_load_addr[len_addr-1:0]] next edge.
//   run_cmd -> RUN; else step_cmd -> STEP (run wins). Write in same cycle still happens.
//  fetch_en = (RUN) | (STEP & step_cmd). Outside fetch_en, PC and IF/ID hold.
//  redirect = fetch_en & (in_pc_src!=0): pc <= target[len_addr-1:0]; IF/ID <= NOP_WORD,
//   out_valid=0 (wrong-path squash). Redirect overrides stall_flag.
//  Sequential fetch = fetch_en & ~redirect & ~stall_flag: IF/ID <= {mem[pc], pc, pc+1},
//   out_valid=1, pc <= pc+1 mod ram_depth (ram_depth-1 wraps to 0). Latency 1 clk PC->ID.
//  stall_flag without redirect: PC, out_instruction, out_pc, out_valid all hold.
//  Halt: sequential fetch reads HALT_WORD -> IF/ID gets HALT_WORD with out_valid=1,
//   out_halt_flag_if=1, state HALT, pc not incremented. Redirect in same cycle wins (no halt).
//  HALT: next edge IF/ID <= NOP_WORD, out_valid=0; all inputs except reset ignored; exit by reset.
//  RUN/STEP ignore in_load_valid (out_load_ready=0, no write). run/step_cmd ignored outside LOAD
//   (step_cmd in STEP only gates fetch).
//  Target addresses wider than len_addr are truncated to low len_addr bits.
// TESTING
//  Load 0..3 = A,B,C,HALT_WORD, run_cmd -> out_instruction A,B,C,HALT on 4 edges, out_pc 0..3,
//   out_halt_flag_if=1 with HALT, state=11, next cycle out_valid=0.
//  RUN, stall_flag high 3 cycles at pc=2 -> out_instruction/out_pc frozen 3 cycles, resumes at 2.
//  in_pc_src=1, in_branch_address=100 with stall_flag=1 -> next out_valid=0/NOP, then out_pc=100.
//  step_cmd pulses x2 with 5 idle cycles between -> exactly 2 valid fetches, PC advances by 2.
//  ram_depth=8, RESET_PC=7, mem[7]=X, mem[0]=Y -> out_pc 7 then 0, out_pc_branch 0 then 1.
//  reset asserted mid-load and in RUN -> all outputs reset values, state LOAD, prior mem kept.

Source files
------------

// File: rtl/if_stage_fsm.sv
// ---------------------------------------------------------------------------
// if_stage_fsm
//
// Instruction-fetch stage of the MIPS pipeline. It holds the instruction
// memory, the word-addressed PC, the next-PC mux and the IF/ID pipeline
// register. A small debug FSM (LOAD / RUN / STEP / HALT) lets the debug unit
// load a program, then free-run it or single-step it. Fetch stops when
// HALT_WORD is fetched, and only a reset leaves HALT.
//
// Ports
//   clk, reset          clock and synchronous active-high reset
//   in_pc_src           next-PC select: 0 seq, 1 branch, 2 jump, 3 register
//   in_branch_address   branch target (word address)
//   in_pc_jump          jump target (word address)
//   in_pc_register      jr/jalr target (word address)
//   stall_flag          hazard stall: PC and IF/ID hold
//   in_load_valid       loader write request (honoured only in LOAD)
//   in_load_addr        loader word address
//   in_load_data        loader instruction word
//   out_load_ready      high only in LOAD
//   run_cmd, step_cmd   debug commands (step_cmd also gates fetch in STEP)
//   out_instruction     IF/ID instruction
//   out_pc              PC of out_instruction, zero-extended
//   out_pc_branch       out_pc + 1 (wrapped), zero-extended
//   out_valid           out_instruction is a real fetched instruction
//   out_halt_flag_if    HALT_WORD has been fetched
//   out_state           00 LOAD, 01 RUN, 10 STEP, 11 HALT
// ---------------------------------------------------------------------------
module if_stage_fsm #(
    parameter int unsigned         len_data  = 32,
    parameter int unsigned         ram_depth = 2048,
    parameter int unsigned         len_addr  = $clog2(ram_depth),
    parameter int unsigned         RESET_PC  = 0,
    parameter logic [len_data-1:0] HALT_WORD = 32'hFFFF_FFFF,
    parameter logic [len_data-1:0] NOP_WORD  = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          in_pc_src,
    input  logic [len_data-1:0] in_branch_address,
    input  logic [len_data-1:0] in_pc_jump,
    input  logic [len_data-1:0] in_pc_register,
    input  logic                stall_flag,
    input  logic                in_load_valid,
    input  logic [len_data-1:0] in_load_addr,
    input  logic [len_data-1:0] in_load_data,
    output logic                out_load_ready,
    input  logic                run_cmd,
    input  logic                step_cmd,
    output logic [len_data-1:0] out_instruction,
    output logic [len_data-1:0] out_pc,
    output logic [len_data-1:0] out_pc_branch,
    output logic                out_valid,
    output logic                out_halt_flag_if,
    output logic [1:0]          out_state
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    localparam logic [len_addr-1:0] LAST_ADDR = len_addr'(ram_depth - 1);

    state_e              state_q, state_d;
    logic [len_addr-1:0] pc_q, pc_d, pc_inc;
    logic [len_data-1:0] instr_q, instr_d;
    logic [len_addr-1:0] if_pc_q, if_pc_d;
    logic [len_addr-1:0] if_pcb_q, if_pcb_d;
    logic                valid_q, valid_d;
    logic                halt_q, halt_d;

    logic [len_data-1:0] mem [ram_depth];
    logic [len_data-1:0] fetch_word;
    logic [len_data-1:0] target;
    logic                fetch_en;
    logic                redirect;
    logic                mem_we;

    // Targets and loader addresses are word addresses truncated to the PC
    // width; the dropped upper bits are collected here on purpose.
    logic unused_hi;
    assign unused_hi = ^{target[len_data-1:len_addr], in_load_addr[len_data-1:len_addr]};

    // Explicit wrap so non-power-of-two depths also return to address 0.
    assign pc_inc     = (pc_q == LAST_ADDR) ? '0 : pc_q + len_addr'(1);
    assign fetch_word = mem[pc_q];

    always_comb begin
        case (in_pc_src)
            2'd1:    target = in_branch_address;
            2'd2:    target = in_pc_jump;
            2'd3:    target = in_pc_register;
            default: target = '0;
        endcase
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        instr_d        = instr_q;
        if_pc_d        = if_pc_q;
        if_pcb_d       = if_pcb_q;
        valid_d        = valid_q;
        halt_d         = halt_q;
        mem_we         = 1'b0;
        out_load_ready = 1'b0;
        fetch_en       = (state_q == ST_RUN) || ((state_q == ST_STEP) && step_cmd);
        redirect       = fetch_en && (in_pc_src != 2'd0);

        case (state_q)
            ST_LOAD: begin
                out_load_ready = 1'b1;
                mem_we         = in_load_valid;
                if (run_cmd) begin
                    state_d = ST_RUN;
                end else if (step_cmd) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN, ST_STEP: begin
                if (redirect) begin
                    // Wrong-path squash: the word at the old PC never reaches ID.
                    pc_d    = target[len_addr-1:0];
                    instr_d = NOP_WORD;
                    valid_d = 1'b0;
                end else if (fetch_en && !stall_flag) begin
                    instr_d  = fetch_word;
                    if_pc_d  = pc_q;
                    if_pcb_d = pc_inc;
                    valid_d  = 1'b1;
                    if (fetch_word == HALT_WORD) begin
                        halt_d  = 1'b1;
                        state_d = ST_HALT;
                    end else begin
                        pc_d = pc_inc;
                    end
                end
            end
            ST_HALT: begin
                instr_d = NOP_WORD;
                valid_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LOAD;
            pc_q     <= len_addr'(RESET_PC);
            instr_q  <= NOP_WORD;
            if_pc_q  <= '0;
            if_pcb_q <= '0;
            valid_q  <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            if_pc_q  <= if_pc_d;
            if_pcb_q <= if_pcb_d;
            valid_q  <= valid_d;
            halt_q   <= halt_d;
        end
    end

    // NOTE: the memory has no reset so a loaded program survives a reset and
    // the array can map onto RAM resources.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem[in_load_addr[len_addr-1:0]] <= in_load_data;
        end
    end

    assign out_instruction  = instr_q;
    assign out_pc           = len_data'(if_pc_q);
    assign out_pc_branch    = len_data'(if_pcb_q);
    assign out_valid        = valid_q;
    assign out_halt_flag_if = halt_q;
    assign out_state        = state_q;

endmodule

// File: tb/tb_if_stage_fsm.sv
// ---------------------------------------------------------------------------
// tb_if_stage_fsm
//
// Drives two instances from shared inputs: a default 2048-word fetch stage
// followed cycle by cycle against a behavioural model, and an 8-word stage
// with RESET_PC=7 used for the reset-PC / wrap scenario. Directed scenarios
// come first, then a randomized run against the same model.
// ---------------------------------------------------------------------------
module tb_if_stage_fsm;

    localparam int          DEPTH = 2048;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] WA    = 32'h2401_0011;
    localparam logic [31:0] WB    = 32'h2402_0022;
    localparam logic [31:0] WC    = 32'h0041_1820;
    localparam logic [31:0] WX    = 32'hAC03_0007;
    localparam logic [31:0] WY    = 32'h8C04_0000;
    localparam logic [31:0] WZ    = 32'h1085_0003;
    localparam int S_LOAD = 0, S_RUN = 1, S_STEP = 2, S_HALT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  in_pc_src;
    logic [31:0] in_branch_address, in_pc_jump, in_pc_register;
    logic        stall_flag, in_load_valid, run_cmd, step_cmd;
    logic [31:0] in_load_addr, in_load_data;

    logic        o_ready, o_valid, o_halt;
    logic [31:0] o_ins, o_pc, o_pcb;
    logic [1:0]  o_state;
    logic        s_ready, s_valid, s_halt;
    logic [31:0] s_ins, s_pc, s_pcb;
    logic [1:0]  s_state;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model of the 2048-word instance.
    logic [31:0] m_mem [DEPTH];
    int          m_state, m_pc, m_opc, m_opcb;
    logic [31:0] m_ins;
    bit          m_valid, m_halt;

    always #5 clk = ~clk;

    if_stage_fsm u_dut (
        .clk(clk), .reset(reset), .in_pc_src(in_pc_src),
        .in_branch_address(in_branch_address), .in_pc_jump(in_pc_jump),
        .in_pc_register(in_pc_register), .stall_flag(stall_flag),
        .in_load_valid(in_load_valid), .in_load_addr(in_load_addr),
        .in_load_data(in_load_data), .out_load_ready(o_ready),
        .run_cmd(run_cmd), .step_cmd(step_cmd), .out_instruction(o_ins),
        .out_pc(o_pc), .out_pc_branch(o_pcb), .out_valid(o_valid),
        .out_halt_flag_if(o_halt), .out_state(o_state)
    );

    if_stage_fsm #(.ram_depth(8), .RESET_PC(7)) u_small (
        .clk(clk), .reset(reset), .in_pc_src(in_pc_src),
        .in_branch_address(in_branch_address), .in_pc_jump(in_pc_jump),
        .in_pc_register(in_pc_register), .stall_flag(stall_flag),
        .in_load_valid(in_load_valid), .in_load_addr(in_load_addr),
        .in_load_data(in_load_data), .out_load_ready(s_ready),
        .run_cmd(run_cmd), .step_cmd(step_cmd), .out_instruction(s_ins),
        .out_pc(s_pc), .out_pc_branch(s_pcb), .out_valid(s_valid),
        .out_halt_flag_if(s_halt), .out_state(s_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Applies one clock edge of the fetch-stage rules to the model.
    task automatic model_edge();
        logic [31:0] w;
        bit          fe;
        if (reset) begin
            m_state = S_LOAD; m_pc = 0; m_ins = NOP;
            m_opc = 0; m_opcb = 0; m_valid = 0; m_halt = 0;
        end else begin
            case (m_state)
                S_LOAD: begin
                    if (in_load_valid) m_mem[int'(in_load_addr % DEPTH)] = in_load_data;
                    if (run_cmd) m_state = S_RUN;
                    else if (step_cmd) m_state = S_STEP;
                end
                S_RUN, S_STEP: begin
                    fe = (m_state == S_RUN) || step_cmd;
                    if (fe && in_pc_src != 2'd0) begin
                        case (in_pc_src)
                            2'd1:    m_pc = int'(in_branch_address % DEPTH);
                            2'd2:    m_pc = int'(in_pc_jump % DEPTH);
                            default: m_pc = int'(in_pc_register % DEPTH);
                        endcase
                        m_ins = NOP; m_valid = 0;
                    end else if (fe && !stall_flag) begin
                        w = m_mem[m_pc];
                        m_ins = w; m_opc = m_pc; m_opcb = (m_pc + 1) % DEPTH; m_valid = 1;
                        if (w == HALT) begin
                            m_halt = 1; m_state = S_HALT;
                        end else begin
                            m_pc = (m_pc + 1) % DEPTH;
                        end
                    end
                end
                default: begin
                    m_ins = NOP; m_valid = 0;
                end
            endcase
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("state", 32'(o_state), 32'(m_state));
        check("out_pc", o_pc, 32'(m_opc));
        check("out_pc_branch", o_pcb, 32'(m_opcb));
        check("instruction", o_ins, m_ins);
        check("valid", 32'(o_valid), 32'(m_valid));
        check("halt_flag", 32'(o_halt), 32'(m_halt));
        check("load_ready", 32'(o_ready), (m_state == S_LOAD) ? 32'd1 : 32'd0);
    endtask

    task automatic idle();
        reset = 0; in_pc_src = 0; in_branch_address = 0; in_pc_jump = 0;
        in_pc_register = 0; stall_flag = 0; in_load_valid = 0;
        in_load_addr = 0; in_load_data = 0; run_cmd = 0; step_cmd = 0;
    endtask

    task automatic load(input int addr, input logic [31:0] data);
        in_load_valid = 1; in_load_addr = 32'(addr); in_load_data = data;
        tick();
        in_load_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        logic [31:0] prog [4];
        logic [31:0] d;
        prog[0] = WA; prog[1] = WB; prog[2] = WC; prog[3] = HALT;
        idle();

        // Reset state of both instances.
        reset = 1;
        tick();
        tick();
        reset = 0;
        check("rst_state", 32'(o_state), 32'd0);
        check("rst_ins", o_ins, NOP);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_small_pc", s_pc, 32'd0);
        check("rst_small_ready", 32'(s_ready), 32'd1);

        // Fill every word with non-halt data so no fetch reads uninitialised memory.
        for (int a = 0; a < DEPTH; a++) begin
            d = $urandom;
            if (d == HALT) d = 32'h1234_5678;
            load(a, d);
        end

        // Program A,B,C,HALT then run to halt.
        for (int i = 0; i < 4; i++) load(i, prog[i]);
        run_cmd = 1; tick(); run_cmd = 0;
        check("run_entered", 32'(o_state), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("prog_ins", o_ins, prog[i]);
            check("prog_pc", o_pc, 32'(i));
        end
        check("halt_flag_set", 32'(o_halt), 32'd1);
        check("halt_state", 32'(o_state), 32'd3);
        tick();
        check("halt_bubble", 32'(o_valid), 32'd0);
        // Inputs other than reset are ignored in HALT.
        run_cmd = 1; in_load_valid = 1; in_load_addr = 3; in_load_data = 0; in_pc_src = 2;
        tick();
        idle();
        check("halt_sticky", 32'(o_state), 32'd3);

        // Reset keeps memory; stall for 3 cycles with pc=2.
        do_reset();
        run_cmd = 1; tick(); run_cmd = 0;
        tick();
        check("kept_mem", o_ins, WA);
        tick();
        stall_flag = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc", o_pc, 32'd1);
            check("stall_ins", o_ins, WB);
        end
        stall_flag = 0;
        tick();
        check("resume_pc", o_pc, 32'd2);

        // Redirect overrides stall, then truncated jump to the last word and wrap.
        in_pc_src = 1; in_branch_address = 100; stall_flag = 1;
        tick();
        check("squash_valid", 32'(o_valid), 32'd0);
        check("squash_ins", o_ins, NOP);
        in_pc_src = 0; stall_flag = 0;
        tick();
        check("branch_pc", o_pc, 32'd100);
        in_pc_src = 2; in_pc_jump = 32'h0001_07FF;
        tick();
        in_pc_src = 0;
        tick();
        check("last_pc", o_pc, 32'd2047);
        check("last_pcb", o_pcb, 32'd0);
        tick();
        check("wrap_pc", o_pc, 32'd0);
        check("wrap_pcb", o_pcb, 32'd1);
        in_pc_src = 3; in_pc_register = 32'h0000_0805;
        tick();
        in_pc_src = 0;
        tick();
        check("jr_pc", o_pc, 32'd5);

        // Single step: two pulses separated by idle cycles give two fetches.
        do_reset();
        step_cmd = 1; tick(); step_cmd = 0;
        check("step_state", 32'(o_state), 32'd2);
        tick();
        check("step_idle", 32'(o_valid), 32'd0);
        step_cmd = 1; tick(); step_cmd = 0;
        check("step1_pc", o_pc, 32'd0);
        for (int i = 0; i < 5; i++) begin
            run_cmd = (i == 2);
            tick();
            check("step_hold", o_pc, 32'd0);
        end
        run_cmd = 0;
        check("step_no_run", 32'(o_state), 32'd2);
        step_cmd = 1; tick(); step_cmd = 0;
        check("step2_pc", o_pc, 32'd1);
        check("step2_ins", o_ins, WB);

        // Reset mid-load keeps earlier writes.
        do_reset();
        load(0, WZ);
        do_reset();
        check("midload_state", 32'(o_state), 32'd0);
        run_cmd = 1; tick(); run_cmd = 0;
        tick();
        check("midload_kept", o_ins, WZ);

        // Small instance: RESET_PC=7 on an 8-word memory wraps to 0.
        do_reset();
        load(7, WX);
        load(0, WY);
        run_cmd = 1; tick(); run_cmd = 0;
        tick();
        check("small_pc7", s_pc, 32'd7);
        check("small_pcb7", s_pcb, 32'd0);
        check("small_ins7", s_ins, WX);
        tick();
        check("small_pc0", s_pc, 32'd0);
        check("small_pcb0", s_pcb, 32'd1);
        check("small_ins0", s_ins, WY);
        do_reset();
        check("small_rst_pc", s_pc, 32'd0);
        check("small_rst_valid", 32'(s_valid), 32'd0);
        check("small_rst_state", 32'(s_state), 32'd0);
        check("small_rst_halt", 32'(s_halt), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset             = ($urandom_range(0, 63) == 0);
            in_load_valid     = !reset && ($urandom_range(0, 1) == 1);
            in_load_addr      = $urandom;
            in_load_data      = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
            run_cmd           = ($urandom_range(0, 7) == 0);
            step_cmd          = ($urandom_range(0, 3) == 0);
            in_pc_src         = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            in_branch_address = $urandom;
            in_pc_jump        = $urandom;
            in_pc_register    = $urandom;
            stall_flag        = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
